gate_response_checker: RTL and testbench

//   Synthesizable response-side checker for the logic_gates unit. It samples
//   the unit's inputs (a, b) and outputs (and_out, or_out, not_out) on a valid

---
 rtl/gate_response_checker_pkg.sv | 22 ++
 rtl/gate_response_checker_if.sv | 40 ++++
 rtl/gate_response_checker_golden.sv | 17 +
 rtl/gate_response_checker.sv | 111 +++++++++++
 tb/tb_gate_response_checker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_response_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_chk_pkg : shared types and golden truth table for the gate checker
// Rev 1.0
// ---------------------------------------------------------------------------
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] COV_ALL = 4'hF;

  // Returns the expected {and, or, not} outputs for one input pair.
  function automatic logic [2:0] gate_golden(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_response_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_response_checker_if : observed gate-unit signals plus checker status
// Rev 1.0
// ---------------------------------------------------------------------------
interface gate_response_checker_if #(
  parameter int CNT_W = 8
) ();

  logic             start;
  logic             sample_valid;
  logic             a;
  logic             b;
  logic             and_out;
  logic             or_out;
  logic             not_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       cov_map;
  logic [2:0]       fail_mask;
  logic [CNT_W-1:0] first_fail_idx;
  logic [1:0]       first_fail_ab;

  modport master (
    output start, sample_valid, a, b, and_out, or_out, not_out,
    input  busy, done, pass, sample_count, err_count, cov_map,
           fail_mask, first_fail_idx, first_fail_ab
  );

  modport slave (
    input  start, sample_valid, a, b, and_out, or_out, not_out,
    output busy, done, pass, sample_count, err_count, cov_map,
           fail_mask, first_fail_idx, first_fail_ab
  );

endinterface
`default_nettype wire

// File: rtl/gate_response_checker_golden.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_golden_model : combinational expected-response generator
// Rev 1.0
// ---------------------------------------------------------------------------
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  wire logic       i_a,
  input  wire logic       i_b,
  output logic      [2:0] o_exp
);

  assign o_exp = gate_golden(i_a, i_b);

endmodule
`default_nettype wire

// File: rtl/gate_response_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_response_checker : compares sampled gate-unit responses with the truth
// table and accumulates error/coverage statistics over one run. Rev 1.0
// ---------------------------------------------------------------------------
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 8,
  parameter int REQUIRE_COV = 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  gate_response_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_err_max = '1;
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(NUM_SAMPLES);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_err_count;
  logic [3:0]       r_cov_map;
  logic [2:0]       r_fail_mask;
  logic [CNT_W-1:0] r_first_fail_idx;
  logic [1:0]       r_first_fail_ab;

  logic [2:0]       w_exp;
  logic [2:0]       w_mis;
  logic             w_fail;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_err_next;
  logic [3:0]       w_cov_next;

  gate_golden_model u_golden (
    .i_a   (bus.a),
    .i_b   (bus.b),
    .o_exp (w_exp)
  );

  assign w_mis      = w_exp ^ {bus.and_out, bus.or_out, bus.not_out};
  assign w_fail     = |w_mis;
  // start has priority: a coincident sample belongs to no run and is dropped
  assign w_accept   = (r_state == RUN) && bus.sample_valid && !bus.start;
  assign w_cnt_next = r_sample_count + c_one;
  assign w_last     = (w_cnt_next == c_last);
  assign w_err_next = (w_fail && (r_err_count != c_err_max)) ?
                      (r_err_count + c_one) : r_err_count;
  assign w_cov_next = r_cov_map | (4'b0001 << {bus.a, bus.b});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_sample_count   <= '0;
      r_err_count      <= '0;
      r_cov_map        <= 4'h0;
      r_fail_mask      <= 3'b000;
      r_first_fail_idx <= '0;
      r_first_fail_ab  <= 2'b00;
    end else if (bus.start) begin
      r_state          <= RUN;
      r_busy           <= 1'b1;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_sample_count   <= '0;
      r_err_count      <= '0;
      r_cov_map        <= 4'h0;
      r_fail_mask      <= 3'b000;
      r_first_fail_idx <= '0;
      r_first_fail_ab  <= 2'b00;
    end else if (w_accept) begin
      r_sample_count <= w_cnt_next;
      r_err_count    <= w_err_next;
      r_cov_map      <= w_cov_next;
      r_fail_mask    <= r_fail_mask | w_mis;
      if (w_fail && (r_err_count == '0)) begin
        r_first_fail_idx <= r_sample_count;
        r_first_fail_ab  <= {bus.a, bus.b};
      end
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= (w_err_next == '0) &&
                   ((REQUIRE_COV == 0) || (w_cov_next == COV_ALL));
      end
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.sample_count   = r_sample_count;
  assign bus.err_count      = r_err_count;
  assign bus.cov_map        = r_cov_map;
  assign bus.fail_mask      = r_fail_mask;
  assign bus.first_fail_idx = r_first_fail_idx;
  assign bus.first_fail_ab  = r_first_fail_ab;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_response_checker : directed stimulus with queued expected reports
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gate_response_checker;

  typedef struct packed {
    logic       pass;
    logic [7:0] cnt;
    logic [7:0] err;
    logic [3:0] cov;
    logic [2:0] fm;
    logic [7:0] ffidx;
    logic [1:0] ffab;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;

  always #5 clk = ~clk;

  gate_response_checker_if #(.CNT_W(8)) if0 ();
  gate_response_checker_if #(.CNT_W(8)) if1 ();
  gate_response_checker_if #(.CNT_W(2)) if2 ();

  // dut1 sees exactly the stimulus of dut0 but does not require coverage
  assign if1.start        = if0.start;
  assign if1.sample_valid = if0.sample_valid;
  assign if1.a            = if0.a;
  assign if1.b            = if0.b;
  assign if1.and_out      = if0.and_out;
  assign if1.or_out       = if0.or_out;
  assign if1.not_out      = if0.not_out;

  gate_response_checker #(.NUM_SAMPLES(4), .CNT_W(8), .REQUIRE_COV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate_response_checker #(.NUM_SAMPLES(4), .CNT_W(8), .REQUIRE_COV(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gate_response_checker #(.NUM_SAMPLES(3), .CNT_W(2), .REQUIRE_COV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  function automatic exp_t mk(input logic p, input logic [7:0] cnt, input logic [7:0] err,
                              input logic [3:0] cov, input logic [2:0] fm,
                              input logic [7:0] ffidx, input logic [1:0] ffab);
    exp_t e;
    e = '{pass: p, cnt: cnt, err: err, cov: cov, fm: fm, ffidx: ffidx, ffab: ffab};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_report(input string tag, input exp_t e, input logic p,
                            input logic [7:0] cnt, input logic [7:0] err, input logic [3:0] cov,
                            input logic [2:0] fm, input logic [7:0] ffidx, input logic [1:0] ffab);
    chk({tag, ".pass"},  32'(p),     32'(e.pass));
    chk({tag, ".count"}, 32'(cnt),   32'(e.cnt));
    chk({tag, ".err"},   32'(err),   32'(e.err));
    chk({tag, ".cov"},   32'(cov),   32'(e.cov));
    chk({tag, ".fmask"}, 32'(fm),    32'(e.fm));
    chk({tag, ".ffidx"}, 32'(ffidx), 32'(e.ffidx));
    chk({tag, ".ffab"},  32'(ffab),  32'(e.ffab));
  endtask

  // Monitors: each rising done pops the next expected report for that DUT.
  always @(negedge clk) begin
    if (rst_n && if0.done && !prev_done0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0 unexpected done: got done=1 expected no report");
      end else begin
        cmp_report("dut0", q0.pop_front(), if0.pass, if0.sample_count, if0.err_count,
                   if0.cov_map, if0.fail_mask, if0.first_fail_idx, if0.first_fail_ab);
      end
    end
    prev_done0 = if0.done;
  end

  always @(negedge clk) begin
    if (rst_n && if1.done && !prev_done1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1 unexpected done: got done=1 expected no report");
      end else begin
        cmp_report("dut1", q1.pop_front(), if1.pass, if1.sample_count, if1.err_count,
                   if1.cov_map, if1.fail_mask, if1.first_fail_idx, if1.first_fail_ab);
      end
    end
    prev_done1 = if1.done;
  end

  always @(negedge clk) begin
    if (rst_n && if2.done && !prev_done2) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut2 unexpected done: got done=1 expected no report");
      end else begin
        cmp_report("dut2", q2.pop_front(), if2.pass, 8'(if2.sample_count), 8'(if2.err_count),
                   if2.cov_map, if2.fail_mask, 8'(if2.first_fail_idx), if2.first_fail_ab);
      end
    end
    prev_done2 = if2.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
  endtask

  task automatic smp(input logic a, input logic b, input logic ao, input logic oo, input logic no);
    if0.sample_valid = 1'b1;
    if0.a = a; if0.b = b;
    if0.and_out = ao; if0.or_out = oo; if0.not_out = no;
    tick();
    if0.sample_valid = 1'b0;
  endtask

  task automatic good(input logic a, input logic b);
    smp(a, b, a & b, a | b, ~a);
  endtask

  task automatic smp2(input logic a, input logic b, input logic ao, input logic oo, input logic no);
    if2.sample_valid = 1'b1;
    if2.a = a; if2.b = b;
    if2.and_out = ao; if2.or_out = oo; if2.not_out = no;
    tick();
    if2.sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic d0);
    int k;
    k = 0;
    while (!(d0 ? if0.done : if2.done) && k < 20) begin
      tick();
      k++;
    end
    chk({name, ".done_seen"}, 32'(d0 ? if0.done : if2.done), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    if0.start = 0; if0.sample_valid = 0; if0.a = 0; if0.b = 0;
    if0.and_out = 0; if0.or_out = 0; if0.not_out = 0;
    if2.start = 0; if2.sample_valid = 0; if2.a = 0; if2.b = 0;
    if2.and_out = 0; if2.or_out = 0; if2.not_out = 0;

    repeat (3) tick();
    chk("reset.busy",  32'(if0.busy), 0);
    chk("reset.done",  32'(if0.done), 0);
    chk("reset.pass",  32'(if0.pass), 0);
    chk("reset.count", 32'(if0.sample_count), 0);
    chk("reset.cov",   32'(if0.cov_map), 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset.busy", 32'(if0.busy), 0);

    // Mid-run reset aborts asynchronously
    pulse_start();
    chk("run.busy", 32'(if0.busy), 1);
    good(0, 0);
    good(0, 1);
    chk("run.count2", 32'(if0.sample_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.busy",  32'(if0.busy), 0);
    chk("async_rst.count", 32'(if0.sample_count), 0);
    chk("async_rst.cov",   32'(if0.cov_map), 0);
    chk("async_rst.dut1_count", 32'(if1.sample_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst.busy", 32'(if0.busy), 0);

    // Good unit, full coverage
    q0.push_back(mk(1, 4, 0, 4'hF, 3'b000, 0, 2'b00));
    q1.push_back(mk(1, 4, 0, 4'hF, 3'b000, 0, 2'b00));
    pulse_start();
    good(0, 0); good(0, 1); good(1, 0); good(1, 1);
    wait_done("good", 1'b1);

    // and_out stuck at 0: only {1,1} mismatches, as the 4th sample
    q0.push_back(mk(0, 4, 1, 4'hF, 3'b100, 3, 2'b11));
    q1.push_back(mk(0, 4, 1, 4'hF, 3'b100, 3, 2'b11));
    pulse_start();
    smp(0, 0, 0, 0, 1); smp(0, 1, 0, 1, 1); smp(1, 0, 0, 1, 0); smp(1, 1, 0, 1, 0);
    wait_done("stuck", 1'b1);

    // Coverage hole: correct outputs, only {0,1}
    q0.push_back(mk(0, 4, 0, 4'b0010, 3'b000, 0, 2'b00));
    q1.push_back(mk(1, 4, 0, 4'b0010, 3'b000, 0, 2'b00));
    pulse_start();
    repeat (4) good(0, 1);
    wait_done("covhole", 1'b1);

    // Restart mid-run, then start/sample collision
    pulse_start();
    smp(1, 1, 0, 1, 0);
    good(0, 0);
    chk("restart.pre_count", 32'(if0.sample_count), 2);
    chk("restart.pre_err",   32'(if0.err_count), 1);
    pulse_start();
    chk("restart.count", 32'(if0.sample_count), 0);
    chk("restart.err",   32'(if0.err_count), 0);
    chk("restart.fmask", 32'(if0.fail_mask), 0);
    chk("restart.busy",  32'(if0.busy), 1);
    if0.start = 1'b1;
    smp(1, 0, 0, 0, 0);
    if0.start = 1'b0;
    chk("collide.count", 32'(if0.sample_count), 0);
    chk("collide.cov",   32'(if0.cov_map), 0);
    chk("collide.fmask", 32'(if0.fail_mask), 0);
    q0.push_back(mk(1, 4, 0, 4'hF, 3'b000, 0, 2'b00));
    q1.push_back(mk(1, 4, 0, 4'hF, 3'b000, 0, 2'b00));
    good(1, 1); good(1, 0); good(0, 1); good(0, 0);
    wait_done("restart", 1'b1);
    smp(1, 1, 0, 0, 0);
    tick();
    chk("in_done.count", 32'(if0.sample_count), 4);
    chk("in_done.err",   32'(if0.err_count), 0);
    chk("in_done.fmask", 32'(if0.fail_mask), 0);
    chk("in_done.done",  32'(if0.done), 1);
    chk("in_done.pass",  32'(if0.pass), 1);

    // Narrow counters, every sample faulty
    q2.push_back(mk(0, 3, 3, 4'b0111, 3'b011, 0, 2'b00));
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    smp2(0, 0, 0, 0, 0); smp2(0, 1, 0, 1, 0); smp2(1, 0, 0, 0, 0);
    wait_done("sat", 1'b0);
    smp2(1, 1, 0, 0, 1);
    tick();
    chk("sat.err_hold",   32'(if2.err_count), 3);
    chk("sat.count_hold", 32'(if2.sample_count), 3);
    chk("sat.done_hold",  32'(if2.done), 1);

    repeat (2) tick();
    chk("q0.drained", 32'(q0.size()), 0);
    chk("q1.drained", 32'(q1.size()), 0);
    chk("q2.drained", 32'(q2.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
